// File: rtl/icache_pkg.sv
// icache_pkg: shared types and default geometry for the n-way instruction cache.
//   state_t    - controller states
//   *_DEF      - default cache geometry
//   OFS_W      - byte offset width within a line (default geometry)
//   IDX_W      - set index width (default geometry)
//   TAG_W      - tag width (default geometry)
//   AGE_W      - per-way LRU age width (default geometry)
package icache_pkg;

  localparam int WAYS_DEF        = 2;
  localparam int SETS_DEF        = 256;
  localparam int LINE_WORDS_DEF  = 8;
  localparam int FETCH_WIDTH_DEF = 4;

  localparam int OFS_W = $clog2(LINE_WORDS_DEF) + 2;
  localparam int IDX_W = $clog2(SETS_DEF);
  localparam int TAG_W = 32 - OFS_W - IDX_W;
  localparam int AGE_W = $clog2(WAYS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL
  } state_t;

endpackage

// File: rtl/icache_way_ram.sv
// icache_way_ram: storage for one cache way (tag + line data per set).
//   clk   - clock
//   we    - write enable
//   waddr - set written
//   wdata - {tag, line data}
//   re    - read enable
//   raddr - set read; data appears on rdata one cycle later
//   rdata - registered read data
module icache_way_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain synchronous RAM, no reset, so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: set-associative instruction cache with true-LRU replacement.
//   clk, resetn         - clock, asynchronous active-low reset
//   req_valid/ready     - fetch request handshake, req_pc = fetch address
//   resp_valid          - single-cycle response strobe
//   resp_inst/resp_mask - FETCH_WIDTH instruction slots and their valid bits
//   flush               - invalidate all lines, cancel in-flight request
//   mem_req_*           - line fill address handshake
//   mem_resp_*          - single-beat line fill data
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS        = WAYS_DEF,
  parameter int SETS        = SETS_DEF,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_pc,
  output logic                      resp_valid,
  output logic [32*FETCH_WIDTH-1:0] resp_inst,
  output logic [FETCH_WIDTH-1:0]    resp_mask,
  input  logic                      flush,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [31:0]               mem_req_addr,
  input  logic                      mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0]  mem_resp_data
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFFSET_W  = WORD_BITS + 2;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int TAG_BITS  = 32 - OFFSET_W - INDEX_W;
  localparam int AGE_BITS  = $clog2(WAYS);
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int RAM_W     = TAG_BITS + LINE_BITS;

  state_t state_q, state_d;
  logic   discard_q, discard_d;

  logic [31:2]          pc_q;
  logic [TAG_BITS-1:0]  tag_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [WORD_BITS-1:0] word_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [AGE_BITS-1:0] age_q   [SETS][WAYS];

  logic [RAM_W-1:0]    way_rdata [WAYS];
  logic [WAYS-1:0]     hit_vec;
  logic                hit;
  logic [AGE_BITS-1:0] hit_way;
  logic [AGE_BITS-1:0] victim;
  logic                victim_found;
  logic [AGE_BITS-1:0] lru_way;
  logic                lru_en;
  logic                fill_we;
  logic [WAYS-1:0]     fill_sel;
  logic                req_fire;
  logic [LINE_BITS-1:0] line_sel;
  logic [WORD_BITS:0]  widx;
  logic                pc_unused;

  // Byte-within-word bits of the PC are don't-care for instruction fetch.
  assign pc_unused = ^req_pc[1:0];

  assign tag_q        = pc_q[31 -: TAG_BITS];
  assign idx_q        = pc_q[OFFSET_W +: INDEX_W];
  assign word_q       = pc_q[2 +: WORD_BITS];
  assign mem_req_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
  assign req_fire     = req_valid && req_ready;

  // One RAM per way; every accepted request reads its set in all ways.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_ram #(
      .WIDTH(RAM_W),
      .DEPTH(SETS)
    ) u_ram (
      .clk  (clk),
      .we   (fill_sel[w]),
      .waddr(idx_q),
      .wdata({tag_q, mem_resp_data}),
      .re   (req_fire),
      .raddr(req_pc[OFFSET_W +: INDEX_W]),
      .rdata(way_rdata[w])
    );
  end

  // Tag compare; should several ways ever match, the lowest index wins.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[idx_q][w] && (way_rdata[w][LINE_BITS +: TAG_BITS] == tag_q);
    hit     = |hit_vec;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = AGE_BITS'(w);
  end

  // Victim: first empty way, otherwise the oldest (age WAYS-1).
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[idx_q][w]) begin
        victim       = AGE_BITS'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found)
      for (int w = 0; w < WAYS; w++)
        if (age_q[idx_q][w] == AGE_BITS'(WAYS - 1)) victim = AGE_BITS'(w);
    fill_sel         = '0;
    fill_sel[victim] = fill_we;
  end

  // State register and discard flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic. A flush in MISS still completes the address handshake
  // so the memory side never sees a withdrawn request; the fill is dropped.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      IDLE:   if (req_fire) state_d = LOOKUP;
      LOOKUP: begin
        if (flush)    state_d = IDLE;
        else if (hit) state_d = req_fire ? LOOKUP : IDLE;
        else          state_d = MISS;
      end
      MISS: begin
        if (flush)         discard_d = 1'b1;
        if (mem_req_ready) state_d   = REFILL;
      end
      REFILL: begin
        if (flush) discard_d = 1'b1;
        if (mem_resp_valid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and array update strobes.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    lru_en        = 1'b0;
    lru_way       = hit_way;
    case (state_q)
      IDLE:   req_ready = !flush;
      LOOKUP: begin
        if (!flush && hit) begin
          req_ready  = 1'b1;
          resp_valid = 1'b1;
          lru_en     = 1'b1;
        end
      end
      MISS:   mem_req_valid = 1'b1;
      REFILL: begin
        if (mem_resp_valid && !flush && !discard_q) begin
          resp_valid = 1'b1;
          fill_we    = 1'b1;
          lru_en     = 1'b1;
          lru_way    = victim;
        end
      end
      default: ;
    endcase
  end

  // Slot extraction from either the hitting way or the incoming fill beat.
  // widx carries one extra bit: when set, the slot ran past the line end.
  always_comb begin
    line_sel  = (state_q == REFILL) ? mem_resp_data : way_rdata[hit_way][LINE_BITS-1:0];
    resp_inst = '0;
    resp_mask = '0;
    widx      = '0;
    if (resp_valid) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        widx = {1'b0, word_q} + (WORD_BITS + 1)'(i);
        if (!widx[WORD_BITS]) begin
          resp_inst[32*i +: 32] = line_sel[{widx[WORD_BITS-1:0], 5'b0} +: 32];
          resp_mask[i]          = 1'b1;
        end
      end
    end
  end

  // Request PC capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       pc_q <= '0;
    else if (req_fire) pc_q <= req_pc[31:2];
  end

  // Valid bits and LRU ages live in flops so a flush clears every set at once.
  // An access moves the way to age 0 and ages every younger way by one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_BITS'(w);
      end
    end else begin
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill_we) begin
        valid_q[idx_q][victim] <= 1'b1;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_BITS'(w) == lru_way)
            age_q[idx_q][w] <= '0;
          else if (age_q[idx_q][w] < age_q[idx_q][lru_way])
            age_q[idx_q][w] <= age_q[idx_q][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed + randomized bench for icache_nway (default geometry).
// Reference model: a recency-ordered list of resident line addresses,
// at most WAYS per set, memory contents from a fixed address function.
module tb_icache_nway;
  import icache_pkg::*;

  localparam int MODEL_WAYS = 1 << AGE_W;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_pc;
  logic         resp_valid;
  logic [127:0] resp_inst;
  logic [3:0]   resp_mask;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [26:0]  res_q[$];
  logic [31:0]  burst_pc [4];
  logic [127:0] b_inst;
  logic [3:0]   b_mask;

  icache_nway dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pc        (req_pc),
    .resp_valid    (resp_valid),
    .resp_inst     (resp_inst),
    .resp_mask     (resp_mask),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  // Backing memory contents; line 0x1000 holds 0x100 + word number.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h80) return 32'h100 + {29'b0, a[4:2]};
    return a ^ 32'h5A5A_0003;
  endfunction

  function automatic logic [255:0] line_data(input logic [26:0] l);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      d[32*k +: 32] = mem_word({l, kk, 2'b00});
    end
    return d;
  endfunction

  function automatic void expect_slots(input logic [31:0] pc, output logic [127:0] inst,
                                       output logic [3:0] mask);
    int w;
    w    = int'(pc[4:2]);
    inst = '0;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (w + i < 8) begin
        logic [2:0] wi;
        wi = 3'(w + i);
        inst[32*i +: 32] = mem_word({pc[31:5], wi, 2'b00});
        mask[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] mk_pc(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] s,
                                        input logic [OFS_W-3:0] w);
    return {t, s, w, 2'b00};
  endfunction

  function automatic bit model_hit(input logic [26:0] l);
    foreach (res_q[i]) if (res_q[i] == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_touch(input logic [26:0] l);
    foreach (res_q[i]) begin
      if (res_q[i] == l) begin
        res_q.delete(i);
        break;
      end
    end
    res_q.push_front(l);
  endfunction

  function automatic void model_fill(input logic [26:0] l);
    int cnt;
    cnt = 0;
    res_q.push_front(l);
    for (int i = 0; i < res_q.size(); i++) begin
      if (res_q[i][7:0] == l[7:0]) begin
        cnt++;
        if (cnt > MODEL_WAYS) begin
          res_q.delete(i);
          break;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One fetch transaction starting from IDLE.
  // mode: 0 normal, 1 flush in REFILL, 2 reset in MISS, 3 flush in MISS, 4 flush in LOOKUP
  task automatic applyStimulus(input logic [31:0] pc, input int mode, input int mdelay,
                               input int rdelay);
    logic [26:0]  line;
    logic [127:0] e_inst;
    logic [3:0]   e_mask;
    bit           hit;
    line = pc[31:5];
    hit  = model_hit(line);
    expect_slots(pc, e_inst, e_mask);

    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    checkOutput("idle_req_ready", req_ready, 1);

    @(negedge clk);
    req_valid = 1'b0;
    flush     = (mode == 4);
    #1;
    if (mode == 4) begin
      checkOutput("lookup_flush_no_resp", resp_valid, 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("lookup_flush_idle", req_ready, 1);
      checkOutput("lookup_flush_no_mem", mem_req_valid, 0);
      res_q.delete();
      return;
    end
    if (hit) begin
      checkOutput("hit_resp_valid", resp_valid, 1);
      checkOutput("hit_inst", resp_inst, e_inst);
      checkOutput("hit_mask", resp_mask, e_mask);
      checkOutput("hit_no_mem_req", mem_req_valid, 0);
      model_touch(line);
      return;
    end
    checkOutput("miss_no_resp", resp_valid, 0);
    checkOutput("miss_req_ready", req_ready, 0);

    for (int c = 0; c <= mdelay; c++) begin
      @(negedge clk);
      flush         = (mode == 3 && c == 0);
      mem_req_ready = (mode != 2) && (c == mdelay);
      #1;
      checkOutput("miss_mem_req_valid", mem_req_valid, 1);
      checkOutput("miss_mem_req_addr", mem_req_addr, {line, 5'b0});
      checkOutput("miss_quiet", resp_valid, 0);
      if (mode == 2) begin
        resetn = 1'b0;
        #1;
        checkOutput("rst_mem_req_drop", mem_req_valid, 0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_inst", resp_inst, 0);
        checkOutput("rst_resp_mask", resp_mask, 0);
        @(negedge clk);
        resetn         = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_data(line);
        #1;
        checkOutput("idle_ignore_resp", resp_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("idle_ignore_resp2", resp_valid, 0);
        checkOutput("idle_after_rst", req_ready, 1);
        mem_resp_valid = 1'b0;
        res_q.delete();
        return;
      end
    end

    for (int c = 0; c <= rdelay; c++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      flush          = (mode == 1 && c == 0);
      mem_resp_valid = (c == rdelay);
      mem_resp_data  = (c == rdelay) ? line_data(line) : '1;
      #1;
      checkOutput("refill_no_mem_req", mem_req_valid, 0);
      if (c < rdelay || mode == 1 || mode == 3) begin
        checkOutput("refill_quiet", resp_valid, 0);
      end else begin
        checkOutput("refill_resp_valid", resp_valid, 1);
        checkOutput("refill_inst", resp_inst, e_inst);
        checkOutput("refill_mask", resp_mask, e_mask);
      end
    end

    @(negedge clk);
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
    #1;
    checkOutput("refill_back_idle", req_ready, 1);
    checkOutput("refill_idle_quiet", resp_valid, 0);
    if (mode == 1 || mode == 3) res_q.delete();
    else model_fill(line);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    req_valid      = 1'b0;
    req_pc         = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_resp_mask", resp_mask, 0);
    checkOutput("reset_resp_inst", resp_inst, 0);
    checkOutput("reset_mem_req_valid", mem_req_valid, 0);
    checkOutput("reset_mem_req_addr", mem_req_addr, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] cold miss and near-end hit");
    applyStimulus(32'h0000_1000, 0, 1, 2);
    applyStimulus(32'h0000_1018, 0, 0, 0);

    $display("[TB] LRU eviction in set 0x80");
    applyStimulus(32'h0000_3000, 0, 0, 1);
    applyStimulus(32'h0000_1000, 0, 0, 0);
    applyStimulus(32'h0000_5000, 0, 2, 0);
    applyStimulus(32'h0000_1004, 0, 0, 0);
    applyStimulus(32'h0000_3000, 0, 0, 0);

    $display("[TB] back-to-back hits");
    burst_pc[0] = 32'h0000_1004;
    burst_pc[1] = 32'h0000_3008;
    burst_pc[2] = 32'h0000_101C;
    burst_pc[3] = 32'h0000_3000;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = burst_pc[0];
    #1;
    checkOutput("burst_accept0", req_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) req_pc = burst_pc[k];
      else       req_valid = 1'b0;
      #1;
      expect_slots(burst_pc[k-1], b_inst, b_mask);
      checkOutput("burst_resp_valid", resp_valid, 1);
      checkOutput("burst_inst", resp_inst, b_inst);
      checkOutput("burst_mask", resp_mask, b_mask);
      if (k < 4) checkOutput("burst_req_ready", req_ready, 1);
      model_touch(burst_pc[k-1][31:5]);
    end
    @(negedge clk);
    #1;
    checkOutput("burst_end_quiet", resp_valid, 0);

    $display("[TB] flush during refill");
    applyStimulus(32'h0000_2000, 1, 0, 2);
    applyStimulus(32'h0000_2000, 0, 0, 0);

    $display("[TB] flush against request in idle");
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h0000_2000;
    #1;
    checkOutput("idle_flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("idle_flush_no_resp", resp_valid, 0);
    res_q.delete();
    applyStimulus(32'h0000_2000, 0, 0, 0);

    $display("[TB] flush in lookup and in miss");
    applyStimulus(32'h0000_2008, 4, 0, 0);
    applyStimulus(32'h0000_2008, 0, 0, 0);
    applyStimulus(32'h0000_4000, 3, 2, 1);
    applyStimulus(32'h0000_4000, 3, 0, 0);
    applyStimulus(32'h0000_4000, 0, 0, 0);

    $display("[TB] reset during miss");
    applyStimulus(32'h0000_6000, 0, 0, 0);
    applyStimulus(32'h0000_7000, 2, 1, 0);
    applyStimulus(32'h0000_6000, 0, 0, 0);
    applyStimulus(32'h0000_4000, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 120; n++) begin
      int          r;
      logic [31:0] pc;
      pc = mk_pc(TAG_W'($urandom_range(0, 3)), IDX_W'(8'h10 + 8'($urandom_range(0, 1))),
                 (OFS_W - 2)'($urandom_range(0, 7)));
      pc[1:0] = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("rand_flush_req_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        res_q.delete();
      end else if (r == 1) begin
        applyStimulus(pc, 1, $urandom_range(0, 2), $urandom_range(1, 3));
      end else if (r == 2) begin
        applyStimulus(pc, 3, $urandom_range(0, 2), $urandom_range(0, 3));
      end else if (r == 3) begin
        applyStimulus(pc, 4, 0, 0);
      end else begin
        applyStimulus(pc, 0, $urandom_range(0, 2), $urandom_range(0, 3));
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised set-associative instruction cache between the fetch stage and the memory bus interface. Each accepted PC returns up to FETCH_WIDTH consecutive 32-bit instructions from one cache line, with a per-slot valid mask. Victims are chosen by true LRU; misses refill a whole line through a valid/ready memory handshake. A global flush invalidates the whole cache.

## Interface
- WAYS, 2: associativity, power of two, 2..8
- SETS, 256: sets, power of two
- LINE_WORDS, 8: 32-bit words per line, power of two, ≥ FETCH_WIDTH
- FETCH_WIDTH, 4: instructions returned per request

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_pc  in  32  fetch PC; bits [1:0] ignored
- resp_valid  out  1  response valid, single cycle, no backpressure
- resp_inst  out  32*FETCH_WIDTH  slot i at [32i+31:32i], slot 0 = word at req_pc
- resp_mask  out  FETCH_WIDTH  bit i set if slot i holds a valid instruction
- flush  in  1  invalidate all lines, cancel in-flight request
- mem_req_valid  out  1  line fill request
- mem_req_ready  in  1  memory accepts address
- mem_req_addr  out  32  line-aligned address
- mem_resp_valid  in  1  fill data valid, one beat
- mem_resp_data  in  32*LINE_WORDS  word k at [32k+31:32k], word 0 lowest address

## Operation
- Address split: offset = log2(LINE_WORDS)+2 bits, index = log2(SETS) bits, tag = remaining upper bits. Defaults: 5 / 8 / 19.
- Per-way storage holds tag and line data. Valid bits and LRU ages are flops, so flush completes in one cycle.
- States:
  - IDLE: req_ready=1. On handshake, latch the PC, issue the RAM read, go to LOOKUP.
  - LOOKUP: compare all ways.
    - Hit: resp_valid=1 and update LRU. req_ready=1, so a new handshake stays in LOOKUP; otherwise go to IDLE.
    - Miss: req_ready=0, go to MISS.
  - MISS: mem_req_valid=1 with mem_req_addr = {tag, index, 0}. Hold until mem_req_ready, then go to REFILL.
  - REFILL: wait for mem_resp_valid. Then write tag, data and valid into the victim, make the victim MRU, respond from mem_resp_data in the same cycle, and go to IDLE.
- Slot extraction: word w = offset[ofs-1:2]. Slot i = word w+i if w+i < LINE_WORDS; otherwise the slot is 0 and its mask bit is clear. There is no line crossing.
- Victim: lowest-index invalid way; if none, the way with age WAYS-1.
- LRU ages: log2(WAYS) bits per way per set. On access to way a: age[a]=0, and every way with age < old age[a] increments. Ages stay a permutation.
- More than one way hitting is impossible by construction. If it happens, the lowest index wins.
- Flush:
  - Clears all valid bits the same cycle.
  - In LOOKUP: suppresses resp_valid, go to IDLE.
  - In MISS: drop mem_req_valid only after the handshake completes; then go to REFILL with the discard flag set.
  - In REFILL: set the discard flag. When mem_resp_valid arrives, write nothing, suppress resp_valid, go to IDLE.
  - With req_valid in IDLE: flush wins and req_ready=0.

## Timing
- Reset: state IDLE, all valid bits 0, age[w]=w in every set, discard flag 0.
- Output values during reset: req_ready=1, resp_valid=0, resp_mask=0, resp_inst=0, mem_req_valid=0, mem_req_addr=0.
- Hit latency: 1 cycle (accept in cycle n, resp_valid in n+1). Back-to-back hits sustain one request per cycle.
- Miss latency: 1 lookup cycle, plus the MISS cycles until mem_req_ready, plus the wait for mem_resp_valid. The response appears in the mem_resp_valid cycle.
- mem_req_valid, once high, stays high with a stable address until mem_req_ready.
- Reset asserted mid-refill returns to IDLE immediately. Any later mem_resp_valid is ignored while in IDLE.

## Structure
- Package icache_pkg: state enum (IDLE, LOOKUP, MISS, REFILL) and clog2-derived width constants (OFS_W, IDX_W, TAG_W, AGE_W).
- Sub-module icache_way_ram, one instance per way: sync read, single write port, 1-cycle read latency, width TAG_W + 32*LINE_WORDS, depth SETS.

## Test plan
- Cold miss, defaults: pc 0x0000_1000. Expect mem_req_addr 0x0000_1000. Respond with word k = 0x100+k; expect resp_inst slots 0x100..0x103 and mask 4'b1111.
- Hit near line end: after the fill, pc 0x0000_1018. Expect 1-cycle latency, slots 0x106, 0x107, 0, 0 and mask 4'b0011.
- LRU eviction: fill 0x1000, 0x3000 (set 0x80, both ways), re-read 0x1000, then miss 0x5000. Expect the 0x3000 way evicted, 0x1000 still hitting, 0x3000 missing.
- Back-to-back hits: req_valid held for 4 cycles on resident PCs. Expect resp_valid on 4 consecutive cycles.
- Flush during REFILL: miss on 0x2000, assert flush before mem_resp_valid. Expect no resp_valid, a return to IDLE, and a repeat of 0x2000 missing again.
- Async reset mid-MISS: mem_req_valid drops in the same cycle. After release, all earlier lines miss.
